dac081s101_tx: RTL and testbench



---
 rtl/dac081s101_tx.sv | 125 ++++++++++++
 tb/tb_dac081s101_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac081s101_tx.sv
// DAC081S101 serial write driver: builds the 16-bit frame and drives SYNC/SCLK/DIN
// with fixed lead, trail and quiet spacing.
module dac081s101_tx #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [1:0] pd_mode,
    output logic       sync_n,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        QUIET
    } state_t;

    localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam bit         HAS_QUIET  = (QUIET_CYCLES != 0);

    state_t      state;
    logic [7:0]  halfCnt;
    logic [4:0]  bitCnt;
    logic [7:0]  quietCnt;
    logic [15:0] shiftReg;
    logic [15:0] frame;
    logic        halfEnd;

    assign frame   = {2'b00, pd_mode, data_in, 4'b0000};
    assign halfEnd = (halfCnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            halfCnt  <= '0;
            bitCnt   <= '0;
            quietCnt <= '0;
            shiftReg <= '0;
            sync_n   <= 1'b1;
            sclk     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= frame;
                        mosi     <= frame[15];
                        sync_n   <= 1'b0;
                        busy     <= 1'b1;
                        halfCnt  <= '0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (halfEnd) begin
                        halfCnt <= '0;
                        bitCnt  <= '0;
                        sclk    <= 1'b0;
                        state   <= SHIFT;
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (halfEnd) begin
                        halfCnt <= '0;
                        if (!sclk) begin
                            // data only moves on the rising edge; zeros follow bit 0
                            sclk     <= 1'b1;
                            shiftReg <= {shiftReg[14:0], 1'b0};
                            mosi     <= shiftReg[14];
                        end else if (bitCnt == 5'd15) begin
                            mosi  <= 1'b0;
                            state <= TRAIL;
                        end else begin
                            bitCnt <= bitCnt + 5'd1;
                            sclk   <= 1'b0;
                        end
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                TRAIL: begin
                    if (halfEnd) begin
                        halfCnt  <= '0;
                        quietCnt <= '0;
                        sync_n   <= 1'b1;
                        done     <= 1'b1;
                        if (HAS_QUIET) begin
                            state <= QUIET;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        halfCnt <= halfCnt + 8'd1;
                    end
                end
                QUIET: begin
                    if (quietCnt == QUIET_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        quietCnt <= quietCnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac081s101_tx.sv
// Bench for dac081s101_tx: three instances (div 1/quiet 4, div 3/quiet 4,
// div 1/quiet 0) checked every cycle against a waveform model.
module tb_dac081s101_tx;

    logic       clk = 1'b0;
    logic [2:0] reset = 3'b111;
    logic [2:0] start = 3'b000;
    logic [2:0] sync_n, sclk, mosi, busy, done;
    logic [7:0] din [3];
    logic [1:0] pd  [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gDut
            dac081s101_tx #(
                .CLK_DIV     (g == 1 ? 3 : 1),
                .QUIET_CYCLES(g == 2 ? 0 : 4)
            ) u (
                .clk    (clk),
                .reset  (reset[g]),
                .start  (start[g]),
                .data_in(din[g]),
                .pd_mode(pd[g]),
                .sync_n (sync_n[g]),
                .sclk   (sclk[g]),
                .mosi   (mosi[g]),
                .busy   (busy[g]),
                .done   (done[g])
            );
        end
    endgenerate

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    endtask

    function automatic int dv(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int qv(input int i);
        return (i == 2) ? 0 : 4;
    endfunction

    // Model: tt = cycles since acceptance (1 = first LEAD cycle), -1 = idle after reset
    function automatic logic [4:0] expOut(input int i, input int tt,
                                          input logic [15:0] f);
        int d, u, p;
        logic sn, sc, mo, bz, dn;
        d  = dv(i);
        sn = 1'b1;
        sc = 1'b1;
        mo = 1'b0;
        if (tt >= 1 && tt <= 34 * d) begin
            sn = 1'b0;
            if (tt <= d) begin
                mo = f[15];
            end else if (tt <= 33 * d) begin
                u = tt - d - 1;
                p = u / (2 * d);
                if (u % (2 * d) < d) begin
                    sc = 1'b0;
                    mo = f[15-p];
                end else if (p < 15) begin
                    mo = f[14-p];
                end
            end
        end
        bz = (tt >= 1 && tt <= 34 * d + qv(i));
        dn = (tt == 34 * d + 1);
        return {sn, sc, mo, bz, dn};
    endfunction

    int          t [3] = '{-1, -1, -1};
    logic [15:0] fr [3];
    int          edges = 0;
    int          acc [3];
    int          accGap [3];

    always @(posedge clk) begin
        edges <= edges + 1;
        for (int i = 0; i < 3; i++) begin
            if (reset[i]) begin
                t[i] <= -1;
            end else if ((t[i] < 0 || t[i] > 34 * dv(i) + qv(i)) && start[i]) begin
                fr[i]     <= {2'b00, pd[i], din[i], 4'h0};
                t[i]      <= 1;
                accGap[i] <= edges - acc[i];
                acc[i]    <= edges;
            end else if (t[i] >= 0) begin
                t[i] <= t[i] + 1;
            end
        end
    end

    bit          pSync [3] = '{1, 1, 1};
    bit          pSclk [3] = '{1, 1, 1};
    bit          pBusy [3] = '{0, 0, 0};
    int          lowRun [3], lowLen [3], highRun [3], minHigh [3];
    int          sRun [3], sMin [3], sMax [3];
    int          capCnt [3], doneAt [3], busyFallAt [3], doneCnt [3];
    logic [15:0] capReg [3], lastCap [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out%0d_t%0d", i, t[i]),
                32'({sync_n[i], sclk[i], mosi[i], busy[i], done[i]}),
                32'(expOut(i, t[i], fr[i])));
            if (!sync_n[i]) begin
                if (pSync[i]) begin
                    if (highRun[i] < minHigh[i]) minHigh[i] = highRun[i];
                    lowRun[i] = 0;
                    capCnt[i] = 0;
                    capReg[i] = '0;
                    sMin[i]   = 999;
                    sMax[i]   = 0;
                end
                lowRun[i]++;
            end else begin
                if (!pSync[i]) begin
                    lowLen[i]  = lowRun[i];
                    highRun[i] = 0;
                end
                highRun[i]++;
            end
            if (pSclk[i] && !sclk[i]) begin
                chk($sformatf("fall_in_frame%0d", i), 32'(sync_n[i]), 0);
                capReg[i] = {capReg[i][14:0], mosi[i]};
                capCnt[i]++;
            end
            if (!sclk[i]) begin
                sRun[i]++;
            end else if (!pSclk[i]) begin
                if (sRun[i] < sMin[i]) sMin[i] = sRun[i];
                if (sRun[i] > sMax[i]) sMax[i] = sRun[i];
                sRun[i] = 0;
            end
            if (done[i]) begin
                doneCnt[i]++;
                doneAt[i] = t[i];
                chk($sformatf("falls%0d", i), 32'(capCnt[i]), 16);
                chk($sformatf("frame%0d", i), 32'(capReg[i]), 32'(fr[i]));
                lastCap[i] = capReg[i];
            end
            if (pBusy[i] && !busy[i]) busyFallAt[i] = t[i];
            pSync[i] = sync_n[i];
            pSclk[i] = sclk[i];
            pBusy[i] = busy[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int i, input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            #1;
            if (done[i]) break;
            k++;
        end
        chk($sformatf("done_seen%0d", i), 32'(done[i]), 1);
    endtask

    task automatic waitIdle(input int i, input int budget);
        int k;
        k = 0;
        while (k < budget && busy[i]) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("idle_seen%0d", i), 32'(busy[i]), 0);
    endtask

    task automatic randPhase(input int i);
        repeat (25) begin
            din[i]   = 8'($urandom);
            pd[i]    = 2'($urandom);
            start[i] = 1'b1;
            tick($urandom_range(1, 3));
            start[i] = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                tick($urandom_range(0, 80));
                reset[i] = 1'b1;
                tick(1);
                reset[i] = 1'b0;
            end
            tick($urandom_range(0, 150));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            pd[i]  = '0;
        end
        tick(3);
        reset = 3'b000;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state%0d", i),
                32'({sync_n[i], sclk[i], mosi[i], busy[i], done[i]}), 32'h18);

        // basic frame
        din[0]   = 8'hA5;
        pd[0]    = 2'b00;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        waitDone(0, 100);
        chk("basic_frame", 32'(lastCap[0]), 32'h0A50);
        chk("basic_sync_low", 32'(lowLen[0]), 34);
        chk("basic_done_cycle", 32'(doneAt[0]), 35);
        waitIdle(0, 50);
        chk("basic_busy_fall", 32'(busyFallAt[0]), 39);

        // divider and power-down bits
        din[1]   = 8'hFF;
        pd[1]    = 2'b11;
        start[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        waitDone(1, 300);
        chk("div3_frame", 32'(lastCap[1]), 32'h3FF0);
        chk("div3_sync_low", 32'(lowLen[1]), 102);
        chk("div3_half_min", 32'(sMin[1]), 3);
        chk("div3_half_max", 32'(sMax[1]), 3);
        waitIdle(1, 50);

        // start held, data changed mid-frame
        tick(1);
        din[0]   = 8'h34;
        pd[0]    = 2'b01;
        start[0] = 1'b1;
        tick(10);
        din[0] = 8'h12;
        pd[0]  = 2'b00;
        waitDone(0, 100);
        chk("hold_first_frame", 32'(lastCap[0]), 32'h1340);
        tick(10);
        start[0] = 1'b0;
        chk("hold_accept_gap", 32'(accGap[0]), 39);
        waitDone(0, 100);
        chk("hold_second_frame", 32'(lastCap[0]), 32'h0120);
        waitIdle(0, 50);

        // reset mid-frame
        tick(1);
        din[0]   = 8'h5A;
        pd[0]    = 2'b10;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        dc = doneCnt[0];
        tick(19);
        reset[0] = 1'b1;
        tick(1);
        #3;
        chk("abort_outputs",
            32'({sync_n[0], sclk[0], mosi[0], busy[0], done[0]}), 32'h18);
        reset[0] = 1'b0;
        din[0]   = 8'hC3;
        pd[0]    = 2'b01;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        waitDone(0, 100);
        chk("after_reset_frame", 32'(lastCap[0]), 32'h1C30);
        chk("abort_no_done", 32'(doneCnt[0] - dc), 1);
        waitIdle(0, 50);

        // zero quiet, back to back
        minHigh[2] = 999;
        dc         = doneCnt[2];
        din[2]     = 8'h77;
        pd[2]      = 2'b00;
        start[2]   = 1'b1;
        tick(100);
        start[2] = 1'b0;
        tick(60);
        chk("q0_done_count", 32'(doneCnt[2] - dc), 3);
        chk("q0_sync_gap", 32'(minHigh[2]), 1);
        chk("q0_frame", 32'(lastCap[2]), 32'h0770);

        fork
            randPhase(0);
            randPhase(1);
            randPhase(2);
        join
        tick(400);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
